// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
//   Shares one word-wide cached-memory user port between instruction fetch
//   (port A, read-only) and data access (port B, read/write). One request is
//   captured at a time. It is driven to memory until the memory accepts it,
//   and read data is returned to the owning port with a one-cycle valid pulse.
//
// Ports
//   i_clk, rst           clock; synchronous active-high reset
//   i_a_req / i_a_addr   port A read request (held until o_a_ack)
//   o_a_ack              port A captured this cycle (combinational)
//   o_a_rvalid/o_a_rdata port A read return (pulse / held data)
//   i_b_req / i_b_wen / i_b_addr / i_b_wdata
//                        port B request; i_b_wen == 0 means read
//   o_b_ack              port B captured this cycle (combinational)
//   o_b_rvalid/o_b_rdata port B read return (pulse / held data)
//   o_mem_ren / o_mem_wen / o_mem_addr / o_mem_data
//                        memory command
//   i_mem_data           memory read data
//   i_mem_stall          memory stall; a command is accepted, or read data is
//                        sampled, on an edge where this is low
//   o_busy               arbiter not idle
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                    i_clk,
  input  logic                    rst,
  input  logic                    i_a_req,
  input  logic [ADDR_WIDTH-1:0]   i_a_addr,
  output logic                    o_a_ack,
  output logic                    o_a_rvalid,
  output logic [DATA_WIDTH-1:0]   o_a_rdata,
  input  logic                    i_b_req,
  input  logic [DATA_WIDTH/8-1:0] i_b_wen,
  input  logic [ADDR_WIDTH-1:0]   i_b_addr,
  input  logic [DATA_WIDTH-1:0]   i_b_wdata,
  output logic                    o_b_ack,
  output logic                    o_b_rvalid,
  output logic [DATA_WIDTH-1:0]   o_b_rdata,
  output logic                    o_mem_ren,
  output logic [DATA_WIDTH/8-1:0] o_mem_wen,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic                    i_mem_stall,
  output logic                    o_busy
);

  localparam int unsigned BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } state_t;

  state_t                  state;

  // Port encodings for r_grant / r_last: 0 = A, 1 = B.
  logic                    r_grant;
  logic                    r_last;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  // Memory command strobes are registered: loaded on capture, cleared on
  // acceptance, so they are zero in IDLE and RDWAIT by construction.
  logic                    r_mem_ren;
  logic [BW-1:0]           r_mem_wen;

  logic                    r_a_rvalid;
  logic                    r_b_rvalid;
  logic [DATA_WIDTH-1:0]   r_a_rdata;
  logic [DATA_WIDTH-1:0]   r_b_rdata;

  logic                    grant_a;
  logic                    grant_b;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [BW-1:0]           sel_wen;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Grant selection, only meaningful in IDLE. On a tie, round-robin grants
  // the port that was not served last; fixed priority always picks B.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (i_a_req && i_b_req) begin
        if (FIXED_PRIO != 0) begin
          grant_b = 1'b1;
        end else if (r_last) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (i_a_req) begin
        grant_a = 1'b1;
      end else if (i_b_req) begin
        grant_b = 1'b1;
      end
    end

    // Port A is always a read: its write enables and data are forced to zero.
    sel_addr  = grant_b ? i_b_addr  : i_a_addr;
    sel_wen   = grant_b ? i_b_wen   : '0;
    sel_wdata = grant_b ? i_b_wdata : '0;
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state      <= IDLE;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_ren  <= 1'b0;
      r_mem_wen  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            r_grant   <= grant_b;
            r_last    <= grant_b;
            r_addr    <= sel_addr;
            r_wdata   <= sel_wdata;
            r_mem_ren <= (sel_wen == '0);
            r_mem_wen <= sel_wen;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (!i_mem_stall) begin
            r_mem_ren <= 1'b0;
            r_mem_wen <= '0;
            // Writes complete on acceptance; reads wait for data.
            state     <= r_mem_ren ? RDWAIT : IDLE;
          end
        end

        RDWAIT: begin
          if (!i_mem_stall) begin
            if (r_grant) begin
              r_b_rdata  <= i_mem_data;
              r_b_rvalid <= 1'b1;
            end else begin
              r_a_rdata  <= i_mem_data;
              r_a_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_a_ack    = grant_a;
  assign o_b_ack    = grant_b;
  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rdata  = r_b_rdata;
  assign o_mem_ren  = r_mem_ren;
  assign o_mem_wen  = r_mem_wen;
  assign o_mem_addr = r_addr;
  assign o_mem_data = r_wdata;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_port_arbiter. Two instances (round-robin and fixed
// priority) share one stimulus set; 'sel' routes requests to one of them and
// selects which one's outputs are observed. Expected read returns are queued
// as requests are granted and popped when an rvalid pulse is seen.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr, b_wdata;
  logic [3:0]  b_wen;
  logic        stall;
  logic [31:0] mem_rdata;
  logic [31:0] pend_addr;
  int          accepts;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  vld;   // {a_rvalid, b_rvalid}
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Per-instance nets
  logic        a_req_r, b_req_r, a_req_f, b_req_f;
  logic        a_ack_r, a_rv_r, b_ack_r, b_rv_r, ren_r, busy_r;
  logic        a_ack_f, a_rv_f, b_ack_f, b_rv_f, ren_f, busy_f;
  logic [31:0] a_rd_r, b_rd_r, addr_r, data_r;
  logic [31:0] a_rd_f, b_rd_f, addr_f, data_f;
  logic [3:0]  wen_r, wen_f;

  assign a_req_r = a_req & ~sel;
  assign b_req_r = b_req & ~sel;
  assign a_req_f = a_req &  sel;
  assign b_req_f = b_req &  sel;

  // Observed (selected) outputs
  logic        a_ack, a_rvalid, b_ack, b_rvalid, mem_ren, busy;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_data;
  logic [3:0]  mem_wen;
  assign a_ack    = sel ? a_ack_f : a_ack_r;
  assign a_rvalid = sel ? a_rv_f  : a_rv_r;
  assign a_rdata  = sel ? a_rd_f  : a_rd_r;
  assign b_ack    = sel ? b_ack_f : b_ack_r;
  assign b_rvalid = sel ? b_rv_f  : b_rv_r;
  assign b_rdata  = sel ? b_rd_f  : b_rd_r;
  assign mem_ren  = sel ? ren_f   : ren_r;
  assign mem_wen  = sel ? wen_f   : wen_r;
  assign mem_addr = sel ? addr_f  : addr_r;
  assign mem_data = sel ? data_f  : data_r;
  assign busy     = sel ? busy_f  : busy_r;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut_rr (
    .i_clk(clk), .rst(rst),
    .i_a_req(a_req_r), .i_a_addr(a_addr), .o_a_ack(a_ack_r),
    .o_a_rvalid(a_rv_r), .o_a_rdata(a_rd_r),
    .i_b_req(b_req_r), .i_b_wen(b_wen), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack_r), .o_b_rvalid(b_rv_r), .o_b_rdata(b_rd_r),
    .o_mem_ren(ren_r), .o_mem_wen(wen_r), .o_mem_addr(addr_r), .o_mem_data(data_r),
    .i_mem_data(mem_rdata), .i_mem_stall(stall), .o_busy(busy_r)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .rst(rst),
    .i_a_req(a_req_f), .i_a_addr(a_addr), .o_a_ack(a_ack_f),
    .o_a_rvalid(a_rv_f), .o_a_rdata(a_rd_f),
    .i_b_req(b_req_f), .i_b_wen(b_wen), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack_f), .o_b_rvalid(b_rv_f), .o_b_rdata(b_rd_f),
    .o_mem_ren(ren_f), .o_mem_wen(wen_f), .o_mem_addr(addr_f), .o_mem_data(data_f),
    .i_mem_data(mem_rdata), .i_mem_stall(stall), .o_busy(busy_f)
  );

  // Memory model: data word is a fixed function of the last accepted read address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  assign mem_rdata = mem_fn(pend_addr);

  always @(posedge clk) begin
    if ((mem_ren || mem_wen != 4'b0) && !stall) begin
      accepts <= accepts + 1;
      if (mem_ren) pend_addr <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (a_rvalid || b_rvalid) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", {62'b0, a_rvalid, b_rvalid}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_port", {62'b0, a_rvalid, b_rvalid}, {62'b0, e.vld});
        chk("rdata", {32'b0, (a_rvalid ? a_rdata : b_rdata)}, {32'b0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Six back-to-back read grants with a request table per window.
  task automatic tie_run(input bit fp);
    logic [1:0]  reqs [6];
    logic [1:0]  expg [6];
    logic [31:0] aa, ba, ea;
    if (fp) begin
      reqs = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01};
      expg = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    end else begin
      reqs = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01};
      expg = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    end
    sel = fp;
    do_reset();
    aa = 32'h200;
    ba = 32'h300;
    b_wen = 4'b0;
    for (int i = 0; i < 6; i++) begin
      {a_req, b_req} = reqs[i];
      a_addr = aa;
      b_addr = ba;
      @(negedge clk);
      chk(fp ? "fp_grant" : "rr_grant", {62'b0, a_ack, b_ack}, {62'b0, expg[i]});
      ea = expg[i][1] ? aa : ba;
      sb.push_back('{vld: expg[i], data: mem_fn(ea)});
      step();
      if (expg[i][1]) begin a_req = 1'b0; aa = aa + 4; end
      else            begin b_req = 1'b0; ba = ba + 4; end
      @(negedge clk);
      chk("busy_no_ack", {61'b0, busy, a_ack, b_ack}, 64'h4);
      step();
      @(negedge clk);
      chk("rdwait_no_ack", {62'b0, a_ack, b_ack}, 64'h0);
      step();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst = 1'b1; sel = 1'b0; a_req = 1'b0; b_req = 1'b0;
    a_addr = '0; b_addr = '0; b_wdata = '0; b_wen = '0; stall = 1'b0;
    pend_addr = '0; accepts = 0;
    step();
    step();
    @(negedge clk);
    chk("reset_strobes", {58'b0, a_ack, b_ack, a_rvalid, b_rvalid, mem_ren, busy}, 64'h0);
    chk("reset_mem_wen", {60'b0, mem_wen}, 64'h0);
    chk("reset_rdata", {a_rdata, b_rdata}, 64'h0);
    step();
    rst = 1'b0;

    // Single A read, no stall
    a_req = 1'b1; a_addr = 32'h100;
    @(negedge clk);
    chk("t1_ack", {61'b0, a_ack, b_ack, busy}, 64'h4);
    sb.push_back('{vld: 2'b10, data: 32'hDEAD_BEEF});
    step();
    a_req = 1'b0;
    @(negedge clk);
    chk("t1_issue", {27'b0, mem_ren, mem_wen, mem_addr}, {27'b0, 1'b1, 4'b0, 32'h100});
    step();
    @(negedge clk);
    chk("t1_rdwait", {61'b0, mem_ren, a_rvalid, busy}, 64'h1);
    step();
    @(negedge clk);
    chk("t1_rvalid", {30'b0, a_rvalid, b_rvalid, a_rdata}, {30'b0, 2'b10, 32'hDEAD_BEEF});
    chk("t1_b_quiet", {62'b0, b_ack, busy}, 64'h0);
    step();
    @(negedge clk);
    chk("t1_rdata_hold", {31'b0, a_rvalid, a_rdata}, {31'b0, 1'b0, 32'hDEAD_BEEF});
    step();

    // Ties: round-robin then fixed priority
    tie_run(1'b0);
    tie_run(1'b1);
    sel = 1'b0;

    // B write with 5 stalled cycles in ISSUE
    do_reset();
    b_req = 1'b1; b_wen = 4'b0011; b_addr = 32'h40; b_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t3_ack", {62'b0, a_ack, b_ack}, 64'h1);
    acc0 = accepts;
    step();
    b_req = 1'b0; b_wen = 4'b0; stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_wen_held", {27'b0, mem_ren, mem_wen, mem_addr}, {27'b0, 1'b0, 4'b0011, 32'h40});
      chk("t3_wdata", {31'b0, busy, mem_data}, {31'b0, 1'b1, 32'h1234_5678});
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t3_wen_last", {60'b0, mem_wen}, 64'h3);
    step();
    @(negedge clk);
    chk("t3_idle", {59'b0, busy, mem_wen}, 64'h0);
    chk("t3_accepts", accepts - acc0, 64'h1);
    step();

    // B read: 2 stalls in ISSUE, 4 in RDWAIT
    b_req = 1'b1; b_wen = 4'b0; b_addr = 32'h80;
    @(negedge clk);
    chk("t4_ack", {62'b0, a_ack, b_ack}, 64'h1);
    sb.push_back('{vld: 2'b01, data: mem_fn(32'h80)});
    acc0 = accepts;
    step();
    b_req = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) stall = 1'b0;
      @(negedge clk);
      chk("t4_issue_ren", {63'b0, mem_ren}, 64'h1);
      step();
    end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_rdwait", {61'b0, mem_ren, b_rvalid, busy}, 64'h1);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t4_sample_no_rv", {63'b0, b_rvalid}, 64'h0);
    step();
    @(negedge clk);
    chk("t4_rvalid", {31'b0, b_rvalid, b_rdata}, {31'b0, 1'b1, mem_fn(32'h80)});
    chk("t4_accepts", accepts - acc0, 64'h1);
    step();

    // Reset during RDWAIT abandons the read
    do_reset();
    a_req = 1'b1; a_addr = 32'h180;
    @(negedge clk);
    chk("t5_ack", {62'b0, a_ack, b_ack}, 64'h2);
    step();
    a_req = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_rdwait", {63'b0, busy}, 64'h1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst", {59'b0, busy, a_rvalid, b_rvalid, mem_ren, (mem_wen != 4'b0)}, 64'h0);
    chk("t5_mem_bus", {mem_addr, mem_data}, 64'h0);
    chk("t5_rdata", {32'b0, a_rdata}, 64'h0);
    step();
    step();
    step();
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h1C0; b_addr = 32'h1E0;
    @(negedge clk);
    chk("t5_tie_grant", {62'b0, a_ack, b_ack}, 64'h2);
    sb.push_back('{vld: 2'b10, data: mem_fn(32'h1C0)});
    step();
    a_req = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t5_b_next", {62'b0, a_ack, b_ack}, 64'h1);
    sb.push_back('{vld: 2'b01, data: mem_fn(32'h1E0)});
    step();
    b_req = 1'b0;
    repeat (4) step();

    chk("sb_drained", sb.size(), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single word-wide cached-memory user port (ren / byte-wen / addr / data / stall) between instruction fetch (port A, read-only) and data access (port B, read/write).
- Captures one request at a time, drives it to memory until accepted, tracks the outstanding read, and returns read data to the owning port with a one-cycle valid pulse.
- Sits between the core's fetch/LSU and the memory controller.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data word width. Byte enables are DATA_WIDTH/8 bits.
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = port B always wins ties.

Ports:
- i_clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_a_req  in  1  port A read request, held until ack
- i_a_addr  in  ADDR_WIDTH  port A address
- o_a_ack  out  1  port A request captured (combinational, single cycle)
- o_a_rvalid  out  1  port A read data valid (one-cycle pulse)
- o_a_rdata  out  DATA_WIDTH  port A read data
- i_b_req  in  1  port B request, held until ack
- i_b_wen  in  DATA_WIDTH/8  port B byte write enables; 0 = read
- i_b_addr  in  ADDR_WIDTH  port B address
- i_b_wdata  in  DATA_WIDTH  port B write data
- o_b_ack  out  1  port B request captured
- o_b_rvalid  out  1  port B read data valid (pulse)
- o_b_rdata  out  DATA_WIDTH  port B read data
- o_mem_ren  out  1  memory read enable
- o_mem_wen  out  DATA_WIDTH/8  memory byte write enables
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_data  out  DATA_WIDTH  memory write data
- i_mem_data  in  DATA_WIDTH  memory read data
- i_mem_stall  in  1  memory stall
- o_busy  out  1  arbiter not in IDLE

Behaviour:
- Memory handshake:
  - A command is accepted at a rising edge where (o_mem_ren or o_mem_wen != 0) and i_mem_stall = 0.
  - Read data is valid on i_mem_data in the first later cycle with i_mem_stall = 0.
- States:
  - IDLE:
    - o_mem_ren = 0 and o_mem_wen = 0.
    - Grant selection:
      - Only one port requesting: that port is granted.
      - Both requesting, FIXED_PRIO = 0: the port not in r_last is granted.
      - Both requesting, FIXED_PRIO = 1: port B is granted.
    - o_x_ack is asserted combinationally for the granted port in this cycle.
    - At the edge: latch grant, addr, wen (A forces 0), and wdata into registers; r_last <= grant; go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE:
    - o_mem_* are driven from the registers: ren = (r_wen == 0), wen = r_wen.
    - Edge with i_mem_stall = 1: hold.
    - Edge with i_mem_stall = 0: a write returns to IDLE (no response); a read goes to RDWAIT.
  - RDWAIT:
    - o_mem_ren = 0 and o_mem_wen = 0.
    - At the first edge with i_mem_stall = 0: register i_mem_data into the granted port's rdata, pulse that port's rvalid in the next cycle, go to IDLE.
- Read data persistence: o_x_rdata holds its value until that port's next read completes.
- Minimum latencies (no stall):
  - Read: ack in cycle 0, issue in cycle 1, data sampled in cycle 2, rvalid in cycle 3.
  - Write: ack in cycle 0, issue in cycle 1, idle again in cycle 2.
- New requests:
  - A new ack is possible in the same cycle as an rvalid pulse, since the arbiter is in IDLE then.
  - Requests arriving while not in IDLE wait; no ack is given.
- o_busy = (state != IDLE).
- Reset:
  - State goes to IDLE; r_last = B, so the first tie grants A under round-robin.
  - All acks, rvalids, o_mem_ren and o_mem_wen are 0; rdata registers and latched request registers are 0.
  - Reset during ISSUE or RDWAIT abandons the transaction; no rvalid is produced.
- Requesters must hold req and payload stable until ack. Dropping req before ack is legal: the request is withdrawn with no side effect.
- Port A with i_b_wen != 0 is not applicable; port A is always a read.

Test Plan:
- Single A read, i_mem_stall = 0, i_mem_data = 0xDEADBEEF at sample:
  - o_a_ack at t0, o_mem_ren = 1 with addr 0x100 at t1, o_a_rvalid = 1 with o_a_rdata = 0xDEADBEEF at t3.
  - B outputs stay quiet throughout.
- Simultaneous A and B requests for 3 back-to-back rounds, round-robin:
  - Grant order is A, B, A, B, A, B.
  - Same stimulus with FIXED_PRIO = 1: B wins every tie; A is served only when B is idle.
- B write with wen = 4'b0011, addr 0x40, data 0x12345678, i_mem_stall held high 5 cycles:
  - o_mem_wen = 0011 held stable all 5 cycles; accepted on the 6th edge; no rvalid on either port; o_busy falls the next cycle.
- B read with stall high for 2 cycles in ISSUE and 4 cycles in RDWAIT:
  - Exactly one o_mem_ren acceptance; o_b_rvalid pulses once, 1 cycle after the first stall-low sample, with the correct data.
- rst asserted during RDWAIT:
  - Next cycle: o_busy = 0, no rvalid ever produced, all o_mem_* = 0.
  - A fresh A/B tie after reset grants A.
